// File: rtl/spi_pkg.sv
// Shared SPI definitions: SPI mode encodings, the engine state type and the
// positions of the CPOL/CPHA bits inside a mode.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[CPOL_BIT];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// Down-counter that measures one SCLK half period; tc_o flags the last
// sys_clock cycle of the loaded interval.
module spi_half_period_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: clear wins over load, load wins over counting down.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master clock engine: generates SCLK for one frame of N bits together
// with sample/shift strobes, bit index and done/aborted completion pulses.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int MAX_BITS = 32,
  parameter int BIT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] clock_div,
  input  logic [1:0]       clock_mode,
  input  logic [BIT_W-1:0] frame_bits,
  output logic             sclk,
  output logic             busy,
  output logic             sample_strobe,
  output logic             shift_strobe,
  output logic [BIT_W-1:0] bit_index,
  output logic             done,
  output logic             aborted
);

  localparam int EW = BIT_W + 1;
  localparam logic [BIT_W-1:0] MAX_BITS_W = BIT_W'(MAX_BITS);

  spi_state_e       state_q;
  logic [1:0]       mode_q;
  logic [BIT_W-1:0] nbits_q;
  logic [DIV_W-1:0] half_q;
  logic [EW-1:0]    edge_cnt_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic             sclk_q;
  logic             busy_q;
  logic             sample_q;
  logic             shift_q;
  logic             done_q;
  logic             aborted_q;

  logic             start_ok_s;
  logic             in_frame_s;
  logic             abort_s;
  logic             tc_s;
  logic             edge_s;
  logic             last_edge_s;
  logic             odd_edge_s;
  logic [EW-1:0]    edge_next_s;
  logic [DIV_W-1:0] half_live_s;
  logic             cnt_load_s;
  logic [DIV_W-1:0] cnt_val_s;

  // Decode of frame acceptance, edge timing and counter reload.
  always_comb begin
    half_live_s = (clock_div == '0) ? DIV_W'(1) : clock_div;
    in_frame_s  = (state_q != ST_IDLE);
    abort_s     = abort && in_frame_s;
    start_ok_s  = (state_q == ST_IDLE) && start &&
                  (frame_bits != '0) && (frame_bits <= MAX_BITS_W);
    edge_next_s = edge_cnt_q + EW'(1);
    last_edge_s = (edge_next_s == {nbits_q, 1'b0});
    odd_edge_s  = edge_next_s[0];
    edge_s      = tc_s && !abort &&
                  ((state_q == ST_SETUP) || (state_q == ST_RUN));
    cnt_load_s  = start_ok_s || edge_s;
    // HOLD lasts one cycle longer than a half period before done is issued.
    if (start_ok_s) begin
      cnt_val_s = half_live_s - DIV_W'(1);
    end else if (last_edge_s) begin
      cnt_val_s = half_q;
    end else begin
      cnt_val_s = half_q - DIV_W'(1);
    end
  end

  spi_half_period_counter #(
    .DIV_W (DIV_W)
  ) u_half_cnt (
    .clk_i      (sys_clock),
    .rst_ni     (reset_n),
    .clr_i      (abort_s),
    .load_i     (cnt_load_s),
    .en_i       (in_frame_s),
    .load_val_i (cnt_val_s),
    .tc_o       (tc_s)
  );

  // Frame state machine with all outputs registered.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      nbits_q    <= '0;
      half_q     <= '0;
      edge_cnt_q <= '0;
      bit_idx_q  <= '0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_s) begin
        state_q    <= ST_IDLE;
        sclk_q     <= mode_cpol(mode_q);
        busy_q     <= 1'b0;
        aborted_q  <= 1'b1;
        edge_cnt_q <= '0;
        bit_idx_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sclk_q     <= mode_cpol(clock_mode);
            edge_cnt_q <= '0;
            bit_idx_q  <= '0;
            if (start_ok_s) begin
              mode_q  <= clock_mode;
              nbits_q <= frame_bits;
              half_q  <= half_live_s;
              busy_q  <= 1'b1;
              state_q <= ST_SETUP;
            end
          end
          ST_SETUP, ST_RUN: begin
            if (edge_s) begin
              sclk_q     <= ~sclk_q;
              edge_cnt_q <= edge_next_s;
              state_q    <= last_edge_s ? ST_HOLD : ST_RUN;
              if (odd_edge_s) begin
                sample_q <= !mode_cpha(mode_q);
                shift_q  <= mode_cpha(mode_q);
              end else begin
                sample_q <= mode_cpha(mode_q);
                shift_q  <= !mode_cpha(mode_q) && !last_edge_s;
                if (!last_edge_s) begin
                  bit_idx_q <= bit_idx_q + BIT_W'(1);
                end
              end
            end
          end
          ST_HOLD: begin
            if (tc_s) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              edge_cnt_q <= '0;
              bit_idx_q  <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sclk          = sclk_q;
  assign busy          = busy_q;
  assign sample_strobe = sample_q;
  assign shift_strobe  = shift_q;
  assign bit_index     = bit_idx_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: directed and random frames compared cycle by
// cycle against a closed-form model of the frame timing.
module tb_spi_sclk_engine;
  import spi_pkg::*;

  localparam int DIV_W    = 8;
  localparam int MAX_BITS = 32;
  localparam int BIT_W    = $clog2(MAX_BITS + 1);

  logic             sys_clock;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] clock_div;
  logic [1:0]       clock_mode;
  logic [BIT_W-1:0] frame_bits;
  logic             sclk;
  logic             busy;
  logic             sample_strobe;
  logic             shift_strobe;
  logic [BIT_W-1:0] bit_index;
  logic             done;
  logic             aborted;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic             sclk;
    logic             busy;
    logic             samp;
    logic             shift;
    logic             done;
    logic             abrt;
    logic [BIT_W-1:0] bidx;
  } obs_t;

  spi_sclk_engine #(
    .DIV_W    (DIV_W),
    .MAX_BITS (MAX_BITS)
  ) dut (
    .sys_clock     (sys_clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .clock_div     (clock_div),
    .clock_mode    (clock_mode),
    .frame_bits    (frame_bits),
    .sclk          (sclk),
    .busy          (busy),
    .sample_strobe (sample_strobe),
    .shift_strobe  (shift_strobe),
    .bit_index     (bit_index),
    .done          (done),
    .aborted       (aborted)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  function automatic obs_t observe();
    obs_t o;
    o.sclk  = sclk;
    o.busy  = busy;
    o.samp  = sample_strobe;
    o.shift = shift_strobe;
    o.done  = done;
    o.abrt  = aborted;
    o.bidx  = bit_index;
    return o;
  endfunction

  // Expected outputs k cycles after the cycle in which start was sampled.
  function automatic obs_t model(input int k, input int h, input int n,
                                 input logic [1:0] mode, input int ab);
    obs_t r;
    int   dc, e, j, bi;
    logic cpol, cpha;
    r    = '0;
    cpol = mode[1];
    cpha = mode[0];
    dc   = 2 + (2 * n + 1) * h;
    if (ab > 0 && k == ab + 1) begin
      r.sclk = cpol;
      r.abrt = 1'b1;
      return r;
    end
    if (k == dc) begin
      r.sclk = cpol;
      r.done = 1'b1;
      return r;
    end
    r.busy = 1'b1;
    e = (k - 1) / h;
    if (e > 2 * n) e = 2 * n;
    r.sclk = cpol ^ e[0];
    if (((k - 1) % h == 0) && ((k - 1) / h >= 1) && ((k - 1) / h <= 2 * n)) begin
      j = (k - 1) / h;
      if (j % 2 == 1) begin
        if (cpha) r.shift = 1'b1;
        else      r.samp  = 1'b1;
      end else begin
        if (cpha)          r.samp  = 1'b1;
        else if (j < 2 * n) r.shift = 1'b1;
      end
    end
    bi = (e / 2 < n - 1) ? e / 2 : n - 1;
    r.bidx = BIT_W'(bi);
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic obs_t idle_exp();
    obs_t x;
    x      = '0;
    x.sclk = clock_mode[CPOL_BIT];
    return x;
  endfunction

  // Start one frame (caller sits at a negedge with the engine idle) and
  // check every cycle up to and including the completion pulse.
  task automatic run_frame(input string tag, input int div, input logic [1:0] mode,
                           input int n, input int ab, input bit hold_start,
                           input bit change_mid, output int done_at, output int edges,
                           output int n_samp, output int n_shift, output int n_done,
                           output int n_abrt);
    int   h, dc, last_k;
    logic prev;
    obs_t o, x;
    done_at = 0; edges = 0; n_samp = 0; n_shift = 0; n_done = 0; n_abrt = 0;
    h      = (div == 0) ? 1 : div;
    dc     = 2 + (2 * n + 1) * h;
    last_k = (ab > 0) ? ab + 1 : dc;
    prev   = mode[1];
    clock_div  = DIV_W'(div);
    clock_mode = mode;
    frame_bits = BIT_W'(n);
    abort      = 1'b0;
    start      = 1'b1;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge sys_clock);
      if (!hold_start) start = 1'b0;
      o = observe();
      x = model(k, h, n, mode, ab);
      chk(tag, k, 32'(o), 32'(x));
      if (o.sclk !== prev) edges++;
      prev = o.sclk;
      if (o.samp)  n_samp++;
      if (o.shift) n_shift++;
      if (o.done) begin
        n_done++;
        done_at = k;
      end
      if (o.abrt) n_abrt++;
      abort = (k == ab);
      if (hold_start && k == dc) start = 1'b0;
      if (change_mid && k == 3) begin
        clock_mode = ~mode;
        clock_div  = 8'd7;
        frame_bits = 6'd9;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    @(negedge sys_clock);
    chk({tag, "_idle"}, last_k + 1, 32'(observe()), 32'(idle_exp()));
  endtask

  initial begin
    int   d, e, ns, nsh, nd, na;
    int   div, n, h, dc, ab;
    logic [1:0] mode;

    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    clock_div  = 8'd1;
    clock_mode = MODE3;
    frame_bits = 6'd1;
    repeat (2) @(negedge sys_clock);
    chk("reset_state", 0, 32'(observe()), 32'd0);
    reset_n = 1'b1;
    @(negedge sys_clock);
    chk("post_reset_cpol", 1, 32'(observe()), 32'(idle_exp()));

    run_frame("m0_h1_n1", 1, MODE0, 1, 0, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("m0_h1_n1_done_at", 0, 32'(d), 32'd5);
    chk("m0_h1_n1_edges", 0, 32'(e), 32'd2);
    chk("m0_h1_n1_samples", 0, 32'(ns), 32'd1);
    chk("m0_h1_n1_shifts", 0, 32'(nsh), 32'd0);

    run_frame("m3_h2_n8", 2, MODE3, 8, 0, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("m3_h2_n8_done_at", 0, 32'(d), 32'd36);
    chk("m3_h2_n8_edges", 0, 32'(e), 32'd16);
    chk("m3_h2_n8_shifts", 0, 32'(nsh), 32'd8);
    chk("m3_h2_n8_samples", 0, 32'(ns), 32'd8);

    run_frame("m1_div0_n4", 0, MODE1, 4, 0, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("m1_div0_done_at", 0, 32'(d), 32'd11);
    run_frame("m1_div1_n4", 1, MODE1, 4, 0, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("m1_div1_done_at", 0, 32'(d), 32'd11);

    run_frame("m2_abort10", 3, MODE2, 8, 10, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("m2_abort10_aborted", 0, 32'(na), 32'd1);
    chk("m2_abort10_no_done", 0, 32'(nd), 32'd0);

    run_frame("abort_last_hold", 2, MODE0, 2, 11, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("abort_last_hold_no_done", 0, 32'(nd), 32'd0);
    run_frame("abort_on_edge", 2, MODE0, 2, 4, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("abort_on_edge_aborted", 0, 32'(na), 32'd1);

    run_frame("start_held", 2, MODE2, 4, 0, 1'b1, 1'b1, d, e, ns, nsh, nd, na);
    chk("start_held_dones", 0, 32'(nd), 32'd1);
    chk("start_held_done_at", 0, 32'(d), 32'd20);
    chk("start_held_edges", 0, 32'(e), 32'd8);

    run_frame("max_div", 255, MODE1, 1, 0, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("max_div_done_at", 0, 32'(d), 32'd767);

    // Starts with an out-of-range frame length and an idle abort are ignored.
    clock_mode = MODE2;
    clock_div  = 8'd1;
    for (int t = 0; t < 3; t++) begin
      frame_bits = (t == 0) ? 6'd0 : 6'd33;
      start      = (t != 2);
      abort      = (t == 2);
      @(negedge sys_clock);
      start = 1'b0;
      abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge sys_clock);
        chk("ignored_request", t, 32'(observe()), 32'(idle_exp()));
      end
    end

    // Reset in the middle of a long frame.
    clock_div  = 8'd2;
    clock_mode = MODE3;
    frame_bits = 6'd32;
    start      = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sys_clock);
      start = 1'b0;
      chk("pre_reset_frame", k, 32'(observe()), 32'(model(k, 2, 32, MODE3, 0)));
    end
    reset_n = 1'b0;
    #1;
    chk("reset_immediate", 0, 32'(observe()), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clock);
      chk("in_reset", c, 32'(observe()), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge sys_clock);
    chk("release_cpol", 0, 32'(observe()), 32'(idle_exp()));
    run_frame("after_reset", 1, MODE2, 3, 0, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
    chk("after_reset_dones", 0, 32'(nd), 32'd1);

    for (int i = 0; i < 20; i++) begin
      div  = $urandom_range(0, 4);
      mode = 2'($urandom_range(0, 3));
      n    = $urandom_range(1, MAX_BITS);
      h    = (div == 0) ? 1 : div;
      dc   = 2 + (2 * n + 1) * h;
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dc - 1) : 0;
      run_frame("random", div, mode, n, ab, 1'b0, 1'b0, d, e, ns, nsh, nd, na);
      if (ab == 0) begin
        chk("random_done_at", i, 32'(d), 32'(dc));
        chk("random_edges", i, 32'(e), 32'(2 * n));
        chk("random_samples", i, 32'(ns), 32'(n));
        chk("random_shifts", i, 32'(nsh), 32'(mode[0] ? n : n - 1));
      end else begin
        chk("random_aborted", i, 32'(na), 32'd1);
        chk("random_abort_no_done", i, 32'(nd), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
SPI_SCLK_ENGINE -- requirements
Module: spi_sclk_engine

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the half-period divider input.
REQ-002 SHALL have parameter MAX_BITS, default 32: longest frame in bits.
REQ-003 SHALL have parameter BIT_W, default $clog2(MAX_BITS+1): width of bit-count ports.
REQ-004 SHALL have port sys_clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request a frame; honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1: terminate the current frame.
REQ-008 SHALL have port clock_div, input, DIV_W: half-period H in sys_clock cycles; 0 treated as 1.
REQ-009 SHALL have port clock_mode, input, 2: [1]=CPOL, [0]=CPHA.
REQ-010 SHALL have port frame_bits, input, BIT_W: bits per frame N, legal range 1..MAX_BITS.
REQ-011 SHALL have port sclk, output, 1: serial clock.
REQ-012 SHALL have port busy, output, 1: frame in progress.
REQ-013 SHALL have port sample_strobe, output, 1: one-cycle pulse on each sampling edge.
REQ-014 SHALL have port shift_strobe, output, 1: one-cycle pulse on each shifting edge.
REQ-015 SHALL have port bit_index, output, BIT_W: index of the current bit, 0..N-1.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-017 SHALL have port aborted, output, 1: one-cycle pulse on abort completion.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, RUN, HOLD; transitions IDLE->SETUP on start, SETUP->RUN after H cycles, RUN->HOLD after edge 2N, HOLD->IDLE after H cycles.
REQ-019 SHALL latch clock_div, clock_mode and frame_bits on the cycle start is accepted; input changes while busy have no effect.
REQ-020 SHALL ignore start while busy, and SHALL ignore start with frame_bits=0 or frame_bits>MAX_BITS (no busy, no done).
REQ-021 SHALL, for start sampled in cycle 0, assert busy from cycle 1, toggle sclk at cycle 1+j*H for edge j=1..2N, deassert busy and pulse done in cycle 2+(2N+1)*H.
REQ-022 SHALL drive sclk=CPOL of the live clock_mode in IDLE and of the latched clock_mode while busy.
REQ-023 SHALL, for CPHA=0, pulse sample_strobe on odd (leading) edges and shift_strobe on even edges 2..2N-2; no shift_strobe on edge 2N.
REQ-024 SHALL, for CPHA=1, pulse shift_strobe on odd edges and sample_strobe on even edges.
REQ-025 SHALL make each strobe coincident with the sys_clock cycle in which sclk changes.
REQ-026 SHALL hold bit_index at 0 in IDLE/SETUP and increment it on each even edge except 2N; it SHALL NOT wrap.
REQ-027 SHALL, on abort while busy, force sclk to latched CPOL, busy=0, and aborted=1 in the next cycle, with no strobes or done; abort in IDLE SHALL be ignored.
REQ-028 SHALL give abort priority over an edge or done scheduled in the same cycle.
REQ-029 SHALL hold sclk constant between edges, without glitches, and SHALL NOT toggle sclk outside RUN.

Reset
REQ-030 SHALL, while reset_n=0, force state=IDLE, sclk=0, busy=0, all strobes/done/aborted=0, bit_index=0, counters=0.
REQ-031 SHALL, after reset release, drive sclk to CPOL of clock_mode in the first cycle.
REQ-032 SHALL, on reset mid-frame, discard the frame with no done or aborted pulse.

Structure
REQ-033 SHALL take mode encodings MODE0..MODE3, state enum, and the CPOL/CPHA bit positions from shared package spi_pkg.
REQ-034 SHALL place the half-period counter (load H, count, terminal pulse) in sub-module spi_half_period_counter, parametrised by DIV_W.

Verification
REQ-035 SHALL cover: mode 0, H=1, N=1, start at cycle 0 -> sclk high at cycle 2, low at cycle 3, sample_strobe at 2, done at cycle 5.
REQ-036 SHALL cover: mode 3, H=2, N=8 -> 16 sclk edges, idle-high sclk, shift_strobe on 8 odd edges, sample_strobe on 8 even edges, done at cycle 36.
REQ-037 SHALL cover: clock_div=0 vs clock_div=1, mode 1, N=4 -> identical waveforms, done at cycle 11.
REQ-038 SHALL cover: abort asserted at cycle 10 of a mode 2, H=3, N=8 frame -> sclk=1, busy=0, aborted=1 at cycle 11, no done.
REQ-039 SHALL cover: start held high while busy and clock_mode changed mid-frame -> single frame, unchanged polarity, one done pulse.
REQ-040 SHALL cover: reset_n low mid-frame (N=MAX_BITS) -> all outputs 0 immediately, no done or aborted, new frame accepted after release.
